serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 77 +++++++
 tb/tb_serial_addsub.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial 8-bit adder/subtractor, one result bit per clock
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, y_q, r_d;
  logic [CW-1:0]    cnt_q;
  logic             c_q, s_d, c_d, last_d, busy_q, done_q, cout_q, ovf_q;
  // full-adder step on the operand LSBs and the running carry
  always_comb begin
    s_d    = a_q[0] ^ b_q[0] ^ c_q;
    c_d    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    r_d    = {s_d, r_q[WIDTH-1:1]};
    last_d = cnt_q == CW'(WIDTH - 1);
  end
  // FSM; DONE accepts a new start directly so back-to-back ops run every WIDTH+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == SHIFT) begin
        r_q   <= r_d;
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        c_q   <= c_d;
        cnt_q <= cnt_q + 1'b1;
        if (last_d) begin
          y_q     <= r_d;
          cout_q  <= c_d;
          ovf_q   <= c_q ^ c_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
      end else if (start) begin
        a_q     <= A;
        b_q     <= op ? ~B : B;
        c_q     <= op;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= SHIFT;
      end else begin
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub with directed vectors
module tb_serial_addsub;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
  logic [7:0] A = '0, B = '0, Y;
  logic       busy, done, cout, ovf;
  int         errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [7:0] y; logic c; logic o; int t;} exp_t;
  exp_t q[$];

  serial_addsub dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
                     .busy(busy), .done(done), .Y(Y), .cout(cout), .ovf(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // expects to be called on a negedge; start is accepted at the following posedge
  task automatic push(input logic o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ey, input logic ec, input logic eo);
    exp_t e;
    op = o; A = a; B = b; start = 1'b1;
    e.y = ey; e.c = ec; e.o = eo; e.t = cyc + 9;
    q.push_back(e);
  endtask

  task automatic do_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ey, input logic ec, input logic eo);
    push(o, a, b, ey, ec, eo);
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_op", busy, 1);
    repeat (9) @(negedge clk);
    chk("busy_after_op", busy, 0);
  endtask

  // monitor: every done pulse must match the oldest expectation in value and cycle
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("Y", Y, e.y);
        chk("cout", cout, e.c);
        chk("ovf", ovf, e.o);
        chk("done_cycle", cyc, e.t);
      end
    end
  end

  initial begin
    #1;
    chk("rst_Y", Y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {cout, ovf}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, 8'h05, 8'h03, 8'h08, 0, 0);
    do_op(1, 8'h05, 8'h03, 8'h02, 1, 0);
    do_op(1, 8'h03, 8'h05, 8'hFE, 0, 0);
    do_op(0, 8'h7F, 8'h01, 8'h80, 0, 1);
    do_op(1, 8'h80, 8'h01, 8'h7F, 1, 1);
    do_op(1, 8'h00, 8'h80, 8'h80, 0, 1);
    do_op(0, 8'hFF, 8'h01, 8'h00, 1, 0);
    do_op(0, 8'h80, 8'h80, 8'h00, 1, 1);
    // mid-operation start pulses with new operands must be ignored
    push(0, 8'h40, 8'h40, 8'h80, 0, 1);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    op = 1'b1; A = 8'h01; B = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'h33; B = 8'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ignored_idle", busy, 0);
    // reset in the middle of SHIFT aborts with no done and clears outputs at once
    op = 1'b0; A = 8'h12; B = 8'h34; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_Y", Y, 8'h80);
    rst_n = 1'b0;
    #1;
    chk("abort_Y", Y, 0);
    chk("abort_busy", busy, 0);
    chk("abort_flags", {done, cout, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_op(0, 8'h10, 8'h20, 8'h30, 0, 0);
    // start held high: a new operation every 9 cycles
    push(0, 8'h01, 8'h02, 8'h03, 0, 0);
    repeat (9) @(negedge clk);
    push(1, 8'h09, 8'h04, 8'h05, 1, 0);
    repeat (9) @(negedge clk);
    push(0, 8'hC8, 8'h64, 8'h2C, 1, 0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("timeout_pending", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
